// File: rtl/drop_actuator.sv
// Hatch controller: it latches a fall time on a qualified request, counts it down in
// prescaled units, holds the hatch open for a fixed window, and then cools down.
module drop_actuator #(
   parameter int CLK_PER_UNIT = 4,
   parameter int HOLD_CYCLES  = 8,
   parameter int COOLDOWN     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        drop_activated,
   input  logic        drop_en,
   input  logic [15:0] t_act,
   input  logic        abort,
   output logic        busy,
   output logic        hatch_open,
   output logic        done,
   output logic        aborted,
   output logic [15:0] remaining,
   output logic [1:0]  fsm_state
);

   localparam int PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
   localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
   localparam int CW = (COOLDOWN     > 1) ? $clog2(COOLDOWN)     : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_UNIT - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_OPEN  = 2'd2,
      S_COOL  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   presc;
   logic [PW-1:0]   presc_next;
   logic [HW-1:0]   hold_cnt;
   logic [HW-1:0]   hold_next;
   logic [CW-1:0]   cool_cnt;
   logic [CW-1:0]   cool_next;
   logic [15:0]     remaining_next;
   logic            req_prev;
   logic            accept;
   logic            busy_next;
   logic            hatch_next;
   logic            done_next;
   logic            aborted_next;

   assign fsm_state = state;

   // The status outputs are registered from the next state, so they never see the inputs combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         presc      <= '0;
         hold_cnt   <= '0;
         cool_cnt   <= '0;
         remaining  <= '0;
         req_prev   <= 1'b0;
         busy       <= 1'b0;
         hatch_open <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         state      <= state_next;
         presc      <= presc_next;
         hold_cnt   <= hold_next;
         cool_cnt   <= cool_next;
         remaining  <= remaining_next;
         req_prev   <= drop_activated;
         busy       <= busy_next;
         hatch_open <= hatch_next;
         done       <= done_next;
         aborted    <= aborted_next;
      end
   end

   always_comb begin
      state_next     = state;
      presc_next     = presc;
      hold_next      = hold_cnt;
      cool_next      = cool_cnt;
      remaining_next = remaining;
      done_next      = 1'b0;
      aborted_next   = 1'b0;
      accept         = drop_activated & ~req_prev & drop_en;

      case (state)
         S_IDLE: begin
            if (accept) begin
               presc_next = '0;
               hold_next  = '0;
               if (t_act != 16'd0) begin
                  state_next     = S_COUNT;
                  remaining_next = t_act;
               end else begin
                  state_next     = S_OPEN;
                  remaining_next = 16'd0;
               end
            end
         end

         S_COUNT: begin
            // Cancellation wins over the final unit wrap on the same edge.
            if (abort || !drop_en) begin
               state_next     = S_IDLE;
               aborted_next   = 1'b1;
               remaining_next = 16'd0;
               presc_next     = '0;
            end else if (presc == PRESC_LAST) begin
               presc_next = '0;
               if (remaining != 16'd0) begin
                  remaining_next = remaining - 16'd1;
               end
               if (remaining <= 16'd1) begin
                  state_next = S_OPEN;
                  hold_next  = '0;
               end
            end else begin
               presc_next = presc + PW'(1);
            end
         end

         S_OPEN: begin
            if (hold_cnt == HOLD_LAST) begin
               state_next = S_COOL;
               hold_next  = '0;
               cool_next  = '0;
               done_next  = 1'b1;
            end else begin
               hold_next = hold_cnt + HW'(1);
            end
         end

         S_COOL: begin
            if (cool_cnt == COOL_LAST) begin
               state_next = S_IDLE;
               cool_next  = '0;
            end else begin
               cool_next = cool_cnt + CW'(1);
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      busy_next  = (state_next != S_IDLE);
      hatch_next = (state_next == S_OPEN);
   end

endmodule
